// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the registered ALU control stage:
// opcode classes, ALU control codes, R-type funct values and FSM states.
package alu_ctrl_pkg;

  // Opcode class presented by the main control unit.
  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,  // lw / sw address generation
    OP_SUB   = 3'b001,  // beq compare
    OP_RTYPE = 3'b010,  // operation selected by funct
    OP_AND   = 3'b011,  // andi
    OP_OR    = 3'b100,  // ori
    OP_SLT   = 3'b101,  // slti
    OP_LUI   = 3'b110,  // lui
    OP_ILL   = 3'b111   // never generated by a legal instruction
  } alu_op_e;

  // 4-bit control code consumed by the ALU / mult-div unit.
  typedef enum logic [3:0] {
    CTR_AND  = 4'b0000,
    CTR_OR   = 4'b0001,
    CTR_ADD  = 4'b0010,
    CTR_SLL  = 4'b0011,
    CTR_SRL  = 4'b0100,
    CTR_XOR  = 4'b0101,
    CTR_SUB  = 4'b0110,
    CTR_SLT  = 4'b0111,
    CTR_MULT = 4'b1000,
    CTR_DIV  = 4'b1001,
    CTR_LUI  = 4'b1010,
    CTR_NOR  = 4'b1100
  } alu_ctr_e;

  // R-type funct encodings recognised by the decoder.
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // Stage occupancy: empty, holding a result, or waiting on mult/div.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FULL    = 2'b01,
    ST_MD_WAIT = 2'b10
  } state_e;

  // Decoded control word for one request.
  typedef struct packed {
    alu_ctr_e ctr;
    logic     illegal;
    logic     is_md;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Request/response bundle of the ALU control stage. The master side is the
// producer of requests and consumer of results; the slave side is the stage.
interface alu_ctrl_seq_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [5:0]       funct;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       alu_ctr;
  logic             illegal;
  logic             md_start;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, alu_op, funct, in_tag, flush, out_ready,
    input  in_ready, out_valid, alu_ctr, illegal, md_start, out_tag
  );

  modport slave (
    input  in_valid, alu_op, funct, in_tag, flush, out_ready,
    output in_ready, out_valid, alu_ctr, illegal, md_start, out_tag
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decoder: {alu_op, funct} -> control code,
// illegal flag and a marker for multi-cycle MULT/DIV operations.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  // Map the opcode class (and funct for R-type) to a control word.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    dec = '{ctr: CTR_ADD, illegal: 1'b0, is_md: 1'b0};
    case (alu_op)
      OP_ADD:  dec.ctr = CTR_ADD;
      OP_SUB:  dec.ctr = CTR_SUB;
      OP_AND:  dec.ctr = CTR_AND;
      OP_OR:   dec.ctr = CTR_OR;
      OP_SLT:  dec.ctr = CTR_SLT;
      OP_LUI:  dec.ctr = CTR_LUI;
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: dec.ctr = CTR_ADD;
          FN_SUB, FN_SUBU: dec.ctr = CTR_SUB;
          FN_AND:          dec.ctr = CTR_AND;
          FN_OR:           dec.ctr = CTR_OR;
          FN_XOR:          dec.ctr = CTR_XOR;
          FN_NOR:          dec.ctr = CTR_NOR;
          FN_SLT:          dec.ctr = CTR_SLT;
          FN_SLL:          dec.ctr = CTR_SLL;
          FN_SRL:          dec.ctr = CTR_SRL;
          FN_MULT: begin
            dec.ctr   = CTR_MULT;
            dec.is_md = 1'b1;
          end
          FN_DIV: begin
            dec.ctr   = CTR_DIV;
            dec.is_md = 1'b1;
          end
          // Unknown funct: flagged, and the ALU sees a harmless ADD.
          default:         dec.illegal = 1'b1;
        endcase
      end
      // Opcode class 111 is never legal.
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control stage. Holds one decoded control word,
// and for MULT/DIV pulses md_start and stays busy for MD_CYCLES cycles before
// presenting the result.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int TAG_W     = 4
) (
  input logic           clk,
  input logic           rst_n,
  alu_ctrl_seq_if.slave bus
);

  localparam int CNT_W = $clog2(MD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);

  if (MD_CYCLES < 1) begin : g_bad_md_cycles
    $error("alu_ctrl_seq: MD_CYCLES must be at least 1");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_ctr_e         alu_ctr_q, alu_ctr_d;
  logic             illegal_q, illegal_d;
  logic             md_start_q, md_start_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  dec_t dec;
  logic accept;

  alu_ctrl_dec u_dec (
    .alu_op (bus.alu_op),
    .funct  (bus.funct),
    .dec    (dec)
  );

  // Handshake signals; in_ready follows out_ready combinationally so a held
  // result can drain and be replaced in the same cycle.
  assign bus.in_ready  = !bus.flush &&
                         (state_q == ST_IDLE || (state_q == ST_FULL && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.alu_ctr   = alu_ctr_q;
  assign bus.illegal   = illegal_q;
  assign bus.md_start  = md_start_q;
  assign bus.out_tag   = out_tag_q;

  // Next state, busy counter and output word.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_ctr_d  = alu_ctr_q;
    illegal_d  = illegal_q;
    out_tag_d  = out_tag_q;
    md_start_d = 1'b0;

    case (state_q)
      ST_FULL: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      ST_MD_WAIT: begin
        // Counter stops at zero, so it can never wrap.
        if (cnt_q == '0) state_d = ST_FULL;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: ;
    endcase

    // A new request either starts a fresh occupancy from IDLE or replaces a
    // result draining this cycle.
    if (accept) begin
      alu_ctr_d = dec.ctr;
      illegal_d = dec.illegal;
      out_tag_d = bus.in_tag;
      if (dec.is_md) begin
        state_d    = ST_MD_WAIT;
        cnt_d      = CNT_LOAD;
        md_start_d = 1'b1;
      end else begin
        state_d = ST_FULL;
      end
    end

    // Flush discards whatever is held or in flight.
    if (bus.flush) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      md_start_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      alu_ctr_q  <= CTR_ADD;
      illegal_q  <= 1'b0;
      md_start_q <= 1'b0;
      out_tag_q  <= '0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // the pre-edge value of its inputs regardless of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_ctr_q  <= alu_ctr_d;
      illegal_q  <= illegal_d;
      md_start_q <= md_start_d;
      out_tag_q  <= out_tag_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: stimulus pushes expected control
// words into a queue, and a monitor pops and compares each delivered result.
module tb_alu_ctrl_seq;

  localparam int TAG_W = 4;
  localparam int MDC   = 4;

  logic clk;
  logic rst_n;

  alu_ctrl_seq_if #(.TAG_W(TAG_W)) bus ();

  alu_ctrl_seq #(.MD_CYCLES(MDC), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [3:0]       ctr;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [5:0] fn;
    logic [3:0] ctr;
    logic       ill;
  } vec_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every delivered result must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(bus.out_tag), 32'hFFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", {bus.alu_ctr, bus.illegal, bus.out_tag}, 32'(e));
        end
      end
    end
  end

  // Present a request and wait (bounded) for acceptance.
  task automatic issue(input logic [2:0] op, input logic [5:0] fn, input logic [3:0] tag,
                       input logic [3:0] ctr, input logic ill, input bit push,
                       output int waits);
    bit done;
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.funct    = fn;
    bus.in_tag   = tag;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 50) begin
          check("accept_timeout", 32'(waits), 0);
          done = 1'b1;
        end
      end
    end
    if (push && waits <= 50) exp_q.push_back('{ctr: ctr, ill: ill, tag: tag});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // After an accepted MULT/DIV: one md_start pulse, busy for MDC cycles,
  // then the result appears.
  task automatic md_wait_check(input string name);
    for (int i = 0; i < MDC; i++) begin
      @(negedge clk);
      check({name, "_busy"}, {bus.in_ready, bus.out_valid}, 0);
      check({name, "_md_start"}, 32'(bus.md_start), (i == 0) ? 1 : 0);
    end
    @(negedge clk);
    check({name, "_valid"}, 32'(bus.out_valid), 1);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  int   w;

  initial begin
    bus.in_valid  = 1'b0;
    bus.alu_op    = 3'b000;
    bus.funct     = 6'b000000;
    bus.in_tag    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_alu_ctr", 32'(bus.alu_ctr), 32'h2);
    check("rst_illegal_md_tag", {bus.illegal, bus.md_start, bus.out_tag}, 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // SLT via R-type: result one cycle after acceptance.
    issue(3'b010, 6'b101010, 4'h3, 4'b0111, 1'b0, 1'b1, w);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("slt_valid_next_cycle", 32'(bus.out_valid), 1);
    idle(2);

    // Back-to-back stream with out_ready held high.
    issue(3'b000, 6'b000000, 4'h1, 4'b0010, 1'b0, 1'b1, w);
    check("b2b_ready0", 32'(w), 0);
    issue(3'b001, 6'b000000, 4'h2, 4'b0110, 1'b0, 1'b1, w);
    check("b2b_ready1", 32'(w), 0);
    issue(3'b010, 6'b100100, 4'h3, 4'b0000, 1'b0, 1'b1, w);
    check("b2b_ready2", 32'(w), 0);
    issue(3'b100, 6'b000000, 4'h4, 4'b0001, 1'b0, 1'b1, w);
    check("b2b_ready3", 32'(w), 0);
    idle(3);

    // MULT: multi-cycle occupancy.
    issue(3'b010, 6'b011000, 4'h5, 4'b1000, 1'b0, 1'b1, w);
    bus.in_valid = 1'b0;
    md_wait_check("mult");
    idle(2);

    // Downstream stall: held word stable, input blocked.
    bus.out_ready = 1'b0;
    issue(3'b011, 6'b000000, 4'h6, 4'b0000, 1'b0, 1'b1, w);
    bus.alu_op = 3'b100;
    bus.in_tag = 4'h7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold", {bus.out_valid, bus.alu_ctr, bus.out_tag, bus.in_ready},
            {1'b1, 4'b0000, 4'h6, 1'b0});
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    issue(3'b100, 6'b000000, 4'h7, 4'b0001, 1'b0, 1'b1, w);
    check("stall_release_ready", 32'(w), 0);
    idle(2);

    // Illegal encodings and the remaining decode table.
    vecs = '{
      '{op: 3'b111, fn: 6'b000000, ctr: 4'b0010, ill: 1'b1},
      '{op: 3'b010, fn: 6'b111111, ctr: 4'b0010, ill: 1'b1},
      '{op: 3'b010, fn: 6'b100111, ctr: 4'b1100, ill: 1'b0},
      '{op: 3'b010, fn: 6'b000000, ctr: 4'b0011, ill: 1'b0},
      '{op: 3'b010, fn: 6'b000010, ctr: 4'b0100, ill: 1'b0},
      '{op: 3'b010, fn: 6'b100110, ctr: 4'b0101, ill: 1'b0},
      '{op: 3'b010, fn: 6'b100001, ctr: 4'b0010, ill: 1'b0},
      '{op: 3'b010, fn: 6'b100011, ctr: 4'b0110, ill: 1'b0},
      '{op: 3'b010, fn: 6'b100101, ctr: 4'b0001, ill: 1'b0},
      '{op: 3'b101, fn: 6'b111111, ctr: 4'b0111, ill: 1'b0},
      '{op: 3'b110, fn: 6'b000000, ctr: 4'b1010, ill: 1'b0},
      '{op: 3'b010, fn: 6'b000001, ctr: 4'b0010, ill: 1'b1}
    };
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].fn, 4'(i), vecs[i].ctr, vecs[i].ill, 1'b1, w);
    end
    idle(3);

    // Flush during MD_WAIT with cnt=2; a simultaneous request is refused.
    issue(3'b010, 6'b011010, 4'hA, 4'b1001, 1'b0, 1'b0, w);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.alu_op   = 3'b000;
    bus.in_tag   = 4'hC;
    @(negedge clk);
    check("flush_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush_no_output", {bus.out_valid, bus.md_start}, 0);
    end
    @(posedge clk);
    #1;
    issue(3'b001, 6'b000000, 4'hB, 4'b0110, 1'b0, 1'b1, w);
    idle(2);

    // Asynchronous reset during MD_WAIT.
    issue(3'b010, 6'b011000, 4'hD, 4'b1000, 1'b0, 1'b0, w);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mdrst_state", {bus.out_valid, bus.in_ready, bus.md_start, bus.illegal}, 32'b0100);
    check("mdrst_word", {bus.alu_ctr, bus.out_tag}, {4'b0010, 4'h0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mdrst_no_output", 32'(bus.out_valid), 0);
    end
    @(posedge clk);
    #1;
    // Full MD latency again shows the counter restarted cleanly.
    issue(3'b010, 6'b011010, 4'hE, 4'b1001, 1'b0, 1'b1, w);
    bus.in_valid = 1'b0;
    md_wait_check("div_after_rst");
    issue(3'b000, 6'b000000, 4'hF, 4'b0010, 1'b0, 1'b1, w);
    idle(4);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
